// File: rtl/input_conditioner.sv
// input_conditioner: per-channel synchronizer, bypassable glitch filter, edge strobes and sticky glitch flags
module input_conditioner #(
  parameter int DATA_WIDTH = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_CYCLES = 4,
  localparam int CNT_W = (FILTER_CYCLES < 2) ? 1 : $clog2(FILTER_CYCLES + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  filt_en,
  input  logic                  glitch_clr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [DATA_WIDTH-1:0] rise,
  output logic [DATA_WIDTH-1:0] fall,
  output logic                  any_edge,
  output logic [DATA_WIDTH-1:0] glitch_sticky
);
  localparam bit FILT = FILTER_CYCLES > 0;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((FILTER_CYCLES > 0) ? FILTER_CYCLES - 1 : 0);
  logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] sync_q, sync_d;
  logic [DATA_WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d, rise_q, rise_d, fall_q, fall_d, glitch_q, glitch_d, upd, lvl;
  logic any_q, any_d;
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], data_in};
    lvl = sync_q[SYNC_STAGES-1];
    data_d = data_q;
    cnt_d = '0;
    upd = '0;
    glitch_d = glitch_q & ~{DATA_WIDTH{glitch_clr}};
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (!(FILT && filt_en)) begin
        data_d[i] = lvl[i];
        upd[i] = lvl[i] ^ data_q[i];
      end else if (lvl[i] == data_q[i]) begin
        glitch_d[i] = glitch_d[i] | (cnt_q[i] != '0);
      end else if (cnt_q[i] == CNT_LAST) begin
        data_d[i] = lvl[i];
        upd[i] = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
    rise_d = upd & lvl;
    fall_d = upd & ~lvl;
    any_d = |(rise_d | fall_d);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      cnt_q <= '0;
      data_q <= '0;
      rise_q <= '0;
      fall_q <= '0;
      any_q <= 1'b0;
      glitch_q <= '0;
    end else begin
      sync_q <= sync_d;
      cnt_q <= cnt_d;
      data_q <= data_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      any_q <= any_d;
      glitch_q <= glitch_d;
    end
  end
  assign data_out = data_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign any_edge = any_q;
  assign glitch_sticky = glitch_q;
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: scoreboard bench comparing two configurations against a behavioural model
module tb_input_conditioner;
  typedef struct packed {
    logic [7:0] d;
    logic [7:0] r;
    logic [7:0] f;
    logic [7:0] g;
    logic       a;
  } exp_t;
  logic clk, rst_n, filt_en, glitch_clr;
  logic [7:0] data_in;
  logic [7:0] a_out, a_rise, a_fall, a_stk, b_out, b_rise, b_fall, b_stk;
  logic a_any, b_any;
  int total = 0, passed = 0;
  exp_t qa[$], qb[$];
  int ss[2] = '{2, 3};
  int ff[2] = '{4, 0};
  logic [7:0] hist[$] = '{8'h0, 8'h0, 8'h0, 8'h0};
  logic [7:0] m_out[2], m_stk[2];
  int m_cnt[2][8];

  input_conditioner #(.DATA_WIDTH(8), .SYNC_STAGES(2), .FILTER_CYCLES(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .filt_en(filt_en), .glitch_clr(glitch_clr), .data_in(data_in),
    .data_out(a_out), .rise(a_rise), .fall(a_fall), .any_edge(a_any), .glitch_sticky(a_stk));
  input_conditioner #(.DATA_WIDTH(8), .SYNC_STAGES(3), .FILTER_CYCLES(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .filt_en(filt_en), .glitch_clr(glitch_clr), .data_in(data_in),
    .data_out(b_out), .rise(b_rise), .fall(b_fall), .any_edge(b_any), .glitch_sticky(b_stk));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: synced level is the input sampled SYNC_STAGES edges ago; a change is
  // accepted once it has been seen on FILTER_CYCLES consecutive filtered edges.
  always @(posedge clk) begin
    exp_t e;
    logic [7:0] v, r, f, set;
    for (int c = 0; c < 2; c++) begin
      e = '0;
      if (rst_n) begin
        v = hist[4 - ss[c]];
        r = '0;
        f = '0;
        set = '0;
        for (int ch = 0; ch < 8; ch++) begin
          if (!(filt_en && ff[c] > 0)) begin
            if (v[ch] != m_out[c][ch]) begin
              r[ch] = v[ch];
              f[ch] = !v[ch];
            end
            m_out[c][ch] = v[ch];
            m_cnt[c][ch] = 0;
          end else if (v[ch] == m_out[c][ch]) begin
            set[ch] = m_cnt[c][ch] != 0;
            m_cnt[c][ch] = 0;
          end else begin
            m_cnt[c][ch] = m_cnt[c][ch] + 1;
            if (m_cnt[c][ch] == ff[c]) begin
              m_out[c][ch] = v[ch];
              m_cnt[c][ch] = 0;
              r[ch] = v[ch];
              f[ch] = !v[ch];
            end
          end
        end
        m_stk[c] = (m_stk[c] & ~{8{glitch_clr}}) | set;
        e = '{d: m_out[c], r: r, f: f, g: m_stk[c], a: |(r | f)};
      end else begin
        m_out[c] = '0;
        m_stk[c] = '0;
        for (int ch = 0; ch < 8; ch++) m_cnt[c][ch] = 0;
      end
      if (c == 0) qa.push_back(e);
      else qb.push_back(e);
    end
    if (!rst_n) hist = '{8'h0, 8'h0, 8'h0, 8'h0};
    else begin
      hist.push_back(data_in);
      void'(hist.pop_front());
    end
  end

  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (qa.size() == 0) begin
      total++;
      $display("FAIL a_queue: got empty expected entry at %0t", $time);
    end else begin
      e = qa.pop_front();
      cmp("a_data_out", a_out, e.d);
      cmp("a_rise", a_rise, e.r);
      cmp("a_fall", a_fall, e.f);
      cmp("a_any_edge", {7'b0, a_any}, {7'b0, e.a});
      cmp("a_glitch_sticky", a_stk, e.g);
    end
    if (qb.size() == 0) begin
      total++;
      $display("FAIL b_queue: got empty expected entry at %0t", $time);
    end else begin
      e = qb.pop_front();
      cmp("b_data_out", b_out, e.d);
      cmp("b_rise", b_rise, e.r);
      cmp("b_fall", b_fall, e.f);
      cmp("b_any_edge", {7'b0, b_any}, {7'b0, e.a});
      cmp("b_glitch_sticky", b_stk, e.g);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    filt_en = 1'b1;
    glitch_clr = 1'b0;
    data_in = '0;
    step(2);
    rst_n = 1'b1;
    step(3);
    data_in[0] = 1'b1;
    step(10);
    data_in[3] = 1'b1;
    step(3);
    data_in[3] = 1'b0;
    step(8);
    glitch_clr = 1'b1;
    step(1);
    glitch_clr = 1'b0;
    step(2);
    filt_en = 1'b0;
    data_in = '0;
    step(6);
    data_in = 8'hA5;
    step(6);
    data_in[6] = 1'b1;
    step(1);
    data_in[6] = 1'b0;
    step(6);
    filt_en = 1'b1;
    data_in = '0;
    step(8);
    data_in[5] = 1'b1;
    step(1);
    data_in[5] = 1'b0;
    step(6);
    data_in[2] = 1'b1;
    step(2);
    data_in[2] = 1'b0;
    step(2);
    glitch_clr = 1'b1;
    step(1);
    glitch_clr = 1'b0;
    step(3);
    data_in[1] = 1'b1;
    step(4);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(10);
    data_in = '0;
    step(6);
    for (int i = 0; i < 8; i++) begin
      data_in = 8'(1 << i);
      step(3);
    end
    data_in = '0;
    step(6);
    repeat (3000) begin
      data_in = data_in ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      if ($urandom_range(0, 99) == 0) filt_en = ~filt_en;
      glitch_clr = $urandom_range(0, 19) == 0;
      rst_n = $urandom_range(0, 299) != 0;
      step(1);
    end
    rst_n = 1'b1;
    glitch_clr = 1'b0;
    step(2);
    @(negedge clk);
    #1;
    cmp("a_queue_drained", 8'(qa.size()), 8'h0);
    cmp("b_queue_drained", 8'(qb.size()), 8'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/input_conditioner.md
# input_conditioner

Parametrised per-channel input conditioner for the logic analyzer front end. It is the next generation of the plain flop-chain synchronizer: a configurable-depth synchronizer per channel, followed by a runtime-bypassable glitch filter and registered rise/fall edge strobes. It sits between the probe pins and the trigger/capture logic, so that trigger comparators see clean, clock-aligned levels and single-cycle edge pulses. It also reports sticky per-channel glitch flags for the host status register.

## Interface
- DATA_WIDTH, 8, number of probe channels (≥1)
- SYNC_STAGES, 2, synchronizer depth per channel (legal 2..4)
- FILTER_CYCLES, 4, consecutive stable cycles required to accept a level change (0 = filter compiled out, legal 0..255)
- CNT_W, derived $clog2(FILTER_CYCLES+1) (min 1), filter counter width; not user-set
- clk  in  1  sole clock
- rst_n  in  1  reset, synchronous, active-low
- filt_en  in  1  1 = glitch filter active, 0 = bypass (synchronous to clk)
- glitch_clr  in  1  1-cycle pulse clears all glitch_sticky bits
- data_in  in  DATA_WIDTH  asynchronous probe inputs
- data_out  out  DATA_WIDTH  conditioned levels
- rise  out  DATA_WIDTH  1-cycle pulse per channel on accepted 0→1
- fall  out  DATA_WIDTH  1-cycle pulse per channel on accepted 1→0
- any_edge  out  1  OR of all rise|fall bits, same cycle
- glitch_sticky  out  DATA_WIDTH  per channel: set when a pending change was aborted

## Operation
- Reset: one clock, synchronous, active-low (rst_n sampled on clk rising edge). While rst_n=0 at an edge: all sync flops, counters, data_out, rise, fall, any_edge and glitch_sticky ← 0.
- Sync: per channel, a SYNC_STAGES-deep flop chain; the last stage is sync_q. No logic between stages.
- Filter, per channel, evaluated each edge when filt_en=1 and FILTER_CYCLES>0:
  - sync_q == data_out: cnt ← 0. If cnt ≠ 0 (pending change aborted), glitch_sticky ← 1.
  - sync_q ≠ data_out and cnt == FILTER_CYCLES-1: data_out ← sync_q, cnt ← 0, update=1.
  - sync_q ≠ data_out otherwise: cnt ← cnt+1.
- Bypass (filt_en=0 or FILTER_CYCLES=0): data_out ← sync_q every edge, cnt ← 0, update = (sync_q ≠ data_out). glitch_sticky is not set.
- Edges: rise ← update & sync_q; fall ← update & ~sync_q. Both are registered in the same edge as data_out, so they are high in exactly the first cycle data_out shows the new level. any_edge ← |(rise_next | fall_next), registered.
- glitch_clr: clears all glitch_sticky bits on the edge it is sampled high. If a set condition occurs on the same edge, set wins for that channel.
- filt_en toggle mid-count: 1→0 takes effect at the next edge (counters cleared, data_out follows sync_q). 0→1 starts from cnt=0.
- Channels are fully independent. There is no cross-channel skew beyond metastability resolution.

## Timing
- Latency, filtered: a data_in step settled before edge 1 appears on data_out, rise and fall after edge SYNC_STAGES+FILTER_CYCLES.
- Latency, bypass: SYNC_STAGES+1 edges. FILTER_CYCLES=1 gives the same latency as bypass.
- Minimum accepted pulse width at data_in (filtered): FILTER_CYCLES clk periods. Shorter pulses produce no data_out change and set glitch_sticky.
- Throughput: one accepted transition per channel at most every FILTER_CYCLES cycles. rise and fall of one channel are never high together.
- Reset exit with data_in=1: after reset, data_out is 0. A rise pulse follows after the normal latency; this is intended.
- Reset mid-count: the pending change is discarded and no glitch is flagged.

## Test plan
- SYNC_STAGES=2, FILTER_CYCLES=4, filt_en=1. data_in[0] steps 0→1 before edge 1 and is held → data_out[0]=1 after edge 6; rise[0] and any_edge high for exactly that cycle; glitch_sticky=0.
- Same configuration. data_in[3] high for 3 cycles, then low → data_out[3] stays 0, no rise or fall, glitch_sticky[3]=1. Then pulse glitch_clr → glitch_sticky=0.
- filt_en=0. data_in=8'hA5 step → data_out=8'hA5 after edge 3. rise=8'hA5 for one cycle, fall=0. No glitch_sticky set for a 1-cycle pulse.
- glitch_clr asserted on the same edge a channel-2 abort occurs → glitch_sticky[2]=1; all other bits cleared.
- Channel 1 with its counter at 2; rst_n=0 for one edge → all outputs 0, cnt=0. With data_in held at 1, data_out[1]=1 and rise[1] occur 6 edges after rst_n returns high.
- SYNC_STAGES=3, FILTER_CYCLES=0 (filter compiled out). Walking-ones pattern on data_in → data_out equals data_in delayed by 4 edges; the rise/fall pattern matches each transition.
